// File: rtl/if_stage_pkg.sv
// if_stage_pkg: shared fetch-stage widths, reset address, stall indices and enable encodings.
package if_stage_pkg;
    localparam int InstAddrBusW = 32;
    localparam int InstBusW = 32;
    localparam int StallW = 6;
    localparam int StallPc = 0;
    localparam int StallIf = 1;
    localparam int StallId = 2;
    localparam logic [InstAddrBusW-1:0] RstPc = 32'h0000_0000;
    localparam logic [InstBusW-1:0] ZeroWord = 32'h0000_0000;
    localparam logic Enable = 1'b1;
    localparam logic Disable = 1'b0;
    localparam logic ChipEnable = 1'b1;
    localparam logic ChipDisable = 1'b0;
endpackage

// File: rtl/pc_reg.sv
// pc_reg: program counter with flush > stall > branch > sequential priority.
// ce_o rises one edge after reset so the first fetch is always RESET_PC.
module pc_reg
    import if_stage_pkg::*;
#(
    parameter logic [InstAddrBusW-1:0] RESET_PC = RstPc,
    parameter logic [InstAddrBusW-1:0] PC_STEP  = 32'd4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    stall_pc_i,
    input  logic                    flush_i,
    input  logic [InstAddrBusW-1:0] new_pc_i,
    input  logic                    branch_flag_i,
    input  logic [InstAddrBusW-1:0] branch_target_address_i,
    output logic [InstAddrBusW-1:0] pc_o,
    output logic                    ce_o,
    output logic [31:0]             branch_cnt_o
);
    logic [InstAddrBusW-1:0] pc_q, pc_d;
    logic [31:0]             cnt_q, cnt_d;
    logic                    ce_q;

    always_comb begin
        pc_d  = pc_q;
        cnt_d = cnt_q;
        if (ce_q == ChipEnable) begin
            if (flush_i) begin
                pc_d = new_pc_i;
            end else if (!stall_pc_i) begin
                pc_d  = branch_flag_i ? branch_target_address_i : pc_q + PC_STEP;
                cnt_d = branch_flag_i ? cnt_q + 32'd1 : cnt_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ce_q  <= ChipDisable;
            pc_q  <= RESET_PC;
            cnt_q <= '0;
        end else begin
            ce_q  <= ChipEnable;
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
        end
    end

    assign pc_o         = pc_q;
    assign ce_o         = ce_q;
    assign branch_cnt_o = cnt_q;
endmodule

// File: rtl/if_stage.sv
// if_stage: fetch front end; PC register plus the IF/ID pipeline latch feeding decode.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [InstAddrBusW-1:0] RESET_PC = RstPc,
    parameter logic [InstAddrBusW-1:0] PC_STEP  = 32'd4,
    parameter int                      STALL_W  = StallW
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [STALL_W-1:0]      stall,
    input  logic                    flush,
    input  logic [InstAddrBusW-1:0] new_pc,
    input  logic                    branch_flag_i,
    input  logic [InstAddrBusW-1:0] branch_target_address_i,
    input  logic [InstBusW-1:0]     rom_data_i,
    output logic [InstAddrBusW-1:0] pc_o,
    output logic                    ce_o,
    output logic [InstAddrBusW-1:0] id_pc_o,
    output logic [InstBusW-1:0]     id_inst_o,
    output logic [31:0]             branch_cnt_o
);
    logic [InstAddrBusW-1:0] id_pc_q, id_pc_d;
    logic [InstBusW-1:0]     id_inst_q, id_inst_d;
    logic                    unused_stall;

    assign unused_stall = ^stall;

    pc_reg #(.RESET_PC(RESET_PC), .PC_STEP(PC_STEP)) u_pc_reg (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .stall_pc_i              (stall[StallPc]),
        .flush_i                 (flush),
        .new_pc_i                (new_pc),
        .branch_flag_i           (branch_flag_i),
        .branch_target_address_i (branch_target_address_i),
        .pc_o                    (pc_o),
        .ce_o                    (ce_o),
        .branch_cnt_o            (branch_cnt_o)
    );

    // IF stalled while ID runs must inject a bubble, not duplicate the instruction.
    always_comb begin
        id_pc_d   = id_pc_q;
        id_inst_d = id_inst_q;
        if (flush || (stall[StallIf] && !stall[StallId])) begin
            id_pc_d   = ZeroWord;
            id_inst_d = ZeroWord;
        end else if (!stall[StallIf]) begin
            id_pc_d   = pc_o;
            id_inst_d = (ce_o == ChipEnable) ? rom_data_i : ZeroWord;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            id_pc_q   <= ZeroWord;
            id_inst_q <= ZeroWord;
        end else begin
            id_pc_q   <= id_pc_d;
            id_inst_q <= id_inst_d;
        end
    end

    assign id_pc_o   = id_pc_q;
    assign id_inst_o = id_inst_q;
endmodule
